// File: rtl/unidade_writeback.sv
// Writeback queue in front of the register file write port, with pending-write lookup.
// Optional macro WB_BYPASS_EN: when defined, byp_dado1/2 forward the youngest pending value.
module unidade_writeback #(
  parameter int unsigned PROF = 4,
  parameter int unsigned LARG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [LARG-1:0] alu_dado,
  output logic            alu_pronto,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [LARG-1:0] mem_dado,
  output logic            mem_pronto,
  input  logic            jal_valid,
  input  logic [31:0]     pc_plus_1,
  output logic            jal_pronto,
  output logic            RegWrite,
  output logic [4:0]      RegD,
  output logic [LARG-1:0] dado_escrita,
  output logic            JAL,
  output logic [31:0]     pc_ra,
  input  logic [4:0]      cons_reg1,
  input  logic [4:0]      cons_reg2,
  output logic            pendente1,
  output logic            pendente2,
  output logic [LARG-1:0] byp_dado1,
  output logic [LARG-1:0] byp_dado2,
  output logic            cheio
);

  localparam int unsigned PW = $clog2(PROF);
  localparam logic [PW:0] ProfC  = (PW+1)'(PROF);
  localparam logic [PW:0] ProfM2 = (PW+1)'(PROF - 2);

  logic [4:0]      fila_rd   [PROF];
  logic [LARG-1:0] fila_dado [PROF];
  logic [PW-1:0]   cab, cauda;
  logic [PW:0]     cont;

  logic          push_mem, push_alu, pop, jal_aceito;
  logic [1:0]    n_push;
  logic [PW-1:0] pos_alu;

  // Ready depends only on the registered count.
  assign mem_pronto = cont < ProfC;
  assign alu_pronto = cont <= ProfM2;
  assign cheio      = cont == ProfC;

  assign push_mem   = mem_valid && mem_pronto && (mem_rd != 5'd0);
  assign push_alu   = alu_valid && alu_pronto && (alu_rd != 5'd0);
  assign pop        = cont != '0;
  assign n_push     = {1'b0, push_mem} + {1'b0, push_alu};
  assign pos_alu    = cauda + PW'(push_mem);
  assign jal_aceito = jal_valid && jal_pronto;

  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    jal_pronto = !(RegWrite && RegD == 5'd31);
    for (int unsigned k = 0; k < PROF; k++) begin
      idx = cab + PW'(k);
      if ((PW+1)'(k) < cont && fila_rd[idx] == 5'd31) jal_pronto = 1'b0;
    end
  end

  // Scan oldest (output stage) to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    logic [LARG-1:0] d1, d2;
    idx       = '0;
    pendente1 = RegWrite && RegD == cons_reg1 && cons_reg1 != 5'd0;
    pendente2 = RegWrite && RegD == cons_reg2 && cons_reg2 != 5'd0;
    d1        = pendente1 ? dado_escrita : '0;
    d2        = pendente2 ? dado_escrita : '0;
    for (int unsigned k = 0; k < PROF; k++) begin
      idx = cab + PW'(k);
      if ((PW+1)'(k) < cont) begin
        if (fila_rd[idx] == cons_reg1 && cons_reg1 != 5'd0) begin
          pendente1 = 1'b1;
          d1        = fila_dado[idx];
        end
        if (fila_rd[idx] == cons_reg2 && cons_reg2 != 5'd0) begin
          pendente2 = 1'b1;
          d2        = fila_dado[idx];
        end
      end
    end
`ifdef WB_BYPASS_EN
    byp_dado1 = d1;
    byp_dado2 = d2;
`else
    byp_dado1 = '0;
    byp_dado2 = '0;
    d1        = '0;
    d2        = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cab          <= '0;
      cauda        <= '0;
      cont         <= '0;
      RegWrite     <= 1'b0;
      RegD         <= '0;
      dado_escrita <= '0;
      JAL          <= 1'b0;
      pc_ra        <= '0;
    end else begin
      JAL <= jal_aceito;
      if (jal_aceito) pc_ra <= pc_plus_1;
      RegWrite <= pop;
      if (pop) begin
        RegD         <= fila_rd[cab];
        dado_escrita <= fila_dado[cab];
      end
      if (push_mem) begin
        fila_rd[cauda]   <= mem_rd;
        fila_dado[cauda] <= mem_dado;
      end
      if (push_alu) begin
        fila_rd[pos_alu]   <= alu_rd;
        fila_dado[pos_alu] <= alu_dado;
      end
      cab   <= cab + PW'(pop);
      cauda <= cauda + PW'(n_push);
      cont  <= cont + (PW+1)'(n_push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_unidade_writeback.sv
// Randomized scoreboard bench for unidade_writeback against a queue-level reference model.
module tb_unidade_writeback;
  localparam int PROF = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, jal_valid;
  logic [4:0]  alu_rd, mem_rd, cons_reg1, cons_reg2, RegD;
  logic [31:0] alu_dado, mem_dado, pc_plus_1, dado_escrita, pc_ra, byp_dado1, byp_dado2;
  logic        alu_pronto, mem_pronto, jal_pronto, RegWrite, JAL, pendente1, pendente2, cheio;

  unidade_writeback #(.PROF(PROF), .LARG(32)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_dado(alu_dado), .alu_pronto(alu_pronto),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_dado(mem_dado), .mem_pronto(mem_pronto),
    .jal_valid(jal_valid), .pc_plus_1(pc_plus_1), .jal_pronto(jal_pronto),
    .RegWrite(RegWrite), .RegD(RegD), .dado_escrita(dado_escrita), .JAL(JAL), .pc_ra(pc_ra),
    .cons_reg1(cons_reg1), .cons_reg2(cons_reg2), .pendente1(pendente1), .pendente2(pendente2),
    .byp_dado1(byp_dado1), .byp_dado2(byp_dado2), .cheio(cheio)
  );

  always #5 clock = ~clock;

  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;

  ent_t        mq[$];     // model: writes waiting behind the output stage
  ent_t        exp_q[$];  // scoreboard: every write the register file must see, in order
  bit          out_v;
  ent_t        out_e;
  bit          jal_e;
  logic [31:0] pc_e;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] rnd_rd();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 5'd31 : 5'(r);
  endfunction

  function automatic bit pend(input logic [4:0] c);
    if (c == 0) return 1'b0;
    if (out_v && out_e.rd == c) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] byp(input logic [4:0] c);
`ifdef WB_BYPASS_EN
    if (c == 0) return 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == c) return mq[i].d;
    if (out_v && out_e.rd == c) return out_e.d;
`endif
    return 32'd0;
  endfunction

  function automatic bit jal_ok();
    return !pend(5'd31);
  endfunction

  // Monitor: every asserted write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_unexpected", 32'(RegD), 32'hFFFF_FFFF);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("write_rd", 32'(RegD), 32'(e.rd));
        chk("write_data", dado_escrita, e.d);
      end
    end
  end

  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      input bit jv, input logic [31:0] jpc, input logic [4:0] c1,
                      input bit rst);
    bit acc_a, acc_m, acc_j;
    alu_valid = av;  alu_rd = ard;  alu_dado = ad;
    mem_valid = mv;  mem_rd = mrd;  mem_dado = md;
    jal_valid = jv;  pc_plus_1 = jpc;
    cons_reg1 = c1;  cons_reg2 = rnd_rd();
    reset     = rst;
    #1;
    chk("alu_pronto", 32'(alu_pronto), 32'(mq.size() <= PROF - 2));
    chk("mem_pronto", 32'(mem_pronto), 32'(mq.size() < PROF));
    chk("cheio", 32'(cheio), 32'(mq.size() == PROF));
    chk("jal_pronto", 32'(jal_pronto), 32'(jal_ok()));
    chk("pendente1", 32'(pendente1), 32'(pend(cons_reg1)));
    chk("pendente2", 32'(pendente2), 32'(pend(cons_reg2)));
    chk("byp_dado1", byp_dado1, byp(cons_reg1));
    chk("byp_dado2", byp_dado2, byp(cons_reg2));
    acc_m = mv && (mq.size() < PROF);
    acc_a = av && (mq.size() <= PROF - 2);
    acc_j = jv && jal_ok();
    @(posedge clock);
    if (rst) begin
      mq.delete(); exp_q.delete();
      out_v = 0; jal_e = 0; pc_e = 0;
    end else begin
      jal_e = acc_j;
      if (acc_j) pc_e = jpc;
      if (mq.size() > 0) begin
        out_e = mq.pop_front();
        out_v = 1;
      end else begin
        out_v = 0;
      end
      if (acc_m && mrd != 0) begin
        mq.push_back('{mrd, md}); exp_q.push_back('{mrd, md});
      end
      if (acc_a && ard != 0) begin
        mq.push_back('{ard, ad}); exp_q.push_back('{ard, ad});
      end
    end
    @(negedge clock);
    #1;
    chk("RegWrite", 32'(RegWrite), 32'(out_v));
    chk("JAL", 32'(JAL), 32'(jal_e));
    chk("pc_ra", pc_ra, pc_e);
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  initial begin
    reset = 1; alu_valid = 0; mem_valid = 0; jal_valid = 0;
    alu_rd = 0; mem_rd = 0; alu_dado = 0; mem_dado = 0; pc_plus_1 = 0;
    cons_reg1 = 0; cons_reg2 = 0;
    out_v = 0; jal_e = 0; pc_e = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("reset_RegWrite", 32'(RegWrite), 0);
    chk("reset_RegD", 32'(RegD), 0);
    chk("reset_dado", dado_escrita, 0);
    chk("reset_JAL", 32'(JAL), 0);
    chk("reset_pc_ra", pc_ra, 0);
    chk("reset_cheio", 32'(cheio), 0);

    // single ALU write to r5
    step(1, 5, 32'hA, 0, 0, 0, 0, 0, 5, 0);
    idle(3, 5);
    // simultaneous mem (older) and alu
    step(1, 4, 32'h22, 1, 3, 32'h11, 0, 0, 3, 0);
    idle(3, 4);
    // fill to full with both paths, then hold alu only
    for (int i = 0; i < 6; i++) step(1, 5'(8 + i), 32'(100 + i), 1, 5'(16 + i), 32'(200 + i),
                                     0, 0, 5'(8 + i), 0);
    for (int i = 0; i < 4; i++) step(1, 5'(24 + i), 32'(300 + i), 0, 0, 0, 0, 0, 9, 0);
    idle(6, 0);
    // rd=0 is swallowed
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 0, 0);
    idle(2, 0);
    // r31 pending blocks JAL
    step(1, 31, 32'h77, 0, 0, 0, 0, 0, 31, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 32'h40, 31, 0);
    idle(2, 31);
    // two writes to r7: youngest forwarded
    step(1, 7, 32'h1, 0, 0, 0, 0, 0, 7, 0);
    step(1, 7, 32'h2, 1, 6, 32'h3, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    // reset mid-queue
    step(1, 9, 32'h9, 1, 10, 32'h10, 0, 0, 9, 0);
    step(1, 11, 32'h11, 1, 12, 32'h12, 0, 0, 9, 1);
    idle(4, 9);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 65, rnd_rd(), $urandom(),
           $urandom_range(0, 99) < 45, rnd_rd(), $urandom(),
           $urandom_range(0, 99) < 20, $urandom(), rnd_rd(),
           $urandom_range(0, 199) == 0);
    end
    idle(PROF + 3, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
